keypad_pin_tx: RTL and testbench

Front-end sender for the automatic cashier: detects card insertion, collects a fixed-length PIN from keypad strobes, and delivers it to the cashier controller.
- Delivery uses a valid/acknowledge handshake.
- It is the transmitting end of the card/PIN interface the controller consumes: `tarjeta_recibida` pulse, then packed PIN.
- Includes an inactivity timeout, a clear key, and a card-removal lockout so one insertion produces exactly one session.

---
 rtl/keypad_pin_tx_if.sv | 33 +++
 rtl/keypad_pin_tx.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_pin_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pin_tx_if.sv
// -----------------------------------------------------------------------------
// keypad_pin_tx_if
// Card/PIN delivery link between the keypad front end (master) and the
// cashier controller (slave).
//   tarjeta_recibida : master -> slave, one-cycle pulse on a new card insertion
//   pin              : master -> slave, packed BCD PIN, first digit in MSB nibble
//   pin_valido       : master -> slave, PIN offered, held until acknowledged
//   pin_ack          : slave -> master, controller accepts the PIN
// -----------------------------------------------------------------------------
interface keypad_pin_tx_if #(
   parameter int DIGITS = 4
) ();

   logic                  tarjeta_recibida;
   logic [4*DIGITS-1:0]   pin;
   logic                  pin_valido;
   logic                  pin_ack;

   modport master (
      output tarjeta_recibida,
      output pin,
      output pin_valido,
      input  pin_ack
   );

   modport slave (
      input  tarjeta_recibida,
      input  pin,
      input  pin_valido,
      output pin_ack
   );

endinterface : keypad_pin_tx_if

// File: rtl/keypad_pin_tx.sv
// -----------------------------------------------------------------------------
// keypad_pin_tx
// Front-end sender for the automatic cashier. Detects a card insertion,
// collects a fixed-length BCD PIN from keypad strobes and offers it to the
// cashier controller with a valid/acknowledge handshake. One insertion yields
// at most one session: after delivery or timeout the card must be removed and
// re-inserted before a new PIN can be captured.
//
// Parameters
//   DIGITS   PIN length in digits (1..15)
//   TIMEOUT  idle cycles allowed between keys while capturing (2..65535)
// Ports
//   clk                single clock, rising edge
//   reset              asynchronous, active-low
//   tarjeta_insertada  card sensor level (synchronous to clk)
//   digito_stb/digito  one-cycle keypress strobe and key value
//   borrar             one-cycle clear-entry strobe
//   pin_bus            card/PIN delivery link (master side)
//   digitos_cnt        digits captured so far
//   timeout            one-cycle pulse on inactivity expiry
//   error_digito       one-cycle pulse on a rejected key (value > 9)
// All outputs are registered.
// -----------------------------------------------------------------------------
module keypad_pin_tx #(
   parameter int DIGITS  = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tarjeta_insertada,
   input  logic             digito_stb,
   input  logic [3:0]       digito,
   input  logic             borrar,
   keypad_pin_tx_if.master  pin_bus,
   output logic [3:0]       digitos_cnt,
   output logic             timeout,
   output logic             error_digito
);

   localparam int          PIN_W      = 4 * DIGITS;
   localparam logic [3:0]  DIGITS_C   = 4'(DIGITS);
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_CAPTURA       = 2'd1,
      ST_ENVIO         = 2'd2,
      ST_ESPERA_RETIRO = 2'd3
   } state_t;

   // A key is accepted only when it is a decimal digit.
   function automatic logic digit_ok(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

   // Shift a new digit into the LSB nibble; the oldest digit ends up in the MSBs.
   function automatic logic [PIN_W-1:0] shift_in(input logic [PIN_W-1:0] p,
                                                  input logic [3:0]       d);
      logic [PIN_W-1:0] r;
      r      = p << 4;
      r[3:0] = d;
      return r;
   endfunction

   state_t            state_q, state_d;
   logic              card_prev_q, card_prev_d;
   logic [PIN_W-1:0]  pin_q, pin_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       timer_q, timer_d;
   logic              tarjeta_recibida_q, tarjeta_recibida_d;
   logic              pin_valido_q, pin_valido_d;
   logic              timeout_q, timeout_d;
   logic              error_digito_q, error_digito_d;
   logic [3:0]        cnt_inc_s;

   assign cnt_inc_s = cnt_q + 4'd1;

   // Next-state and output computation for the session FSM.
   always_comb begin
      state_d            = state_q;
      card_prev_d        = tarjeta_insertada;
      pin_d              = pin_q;
      cnt_d              = cnt_q;
      timer_d            = timer_q;
      tarjeta_recibida_d = 1'b0;
      pin_valido_d       = pin_valido_q;
      timeout_d          = 1'b0;
      error_digito_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pin_valido_d = 1'b0;
            // Only a fresh insertion edge opens a session; key strobes are ignored.
            if (tarjeta_insertada && !card_prev_q) begin
               tarjeta_recibida_d = 1'b1;
               pin_d              = '0;
               cnt_d              = 4'd0;
               timer_d            = 16'd0;
               state_d            = ST_CAPTURA;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_CAPTURA: begin
            pin_valido_d = 1'b0;
            if (!tarjeta_insertada) begin
               // Card pulled mid-entry: abandon silently.
               pin_d   = '0;
               cnt_d   = 4'd0;
               timer_d = 16'd0;
               state_d = ST_IDLE;
            end else if (borrar) begin
               // Clear wins over a same-cycle digit, which is discarded.
               pin_d   = '0;
               cnt_d   = 4'd0;
               timer_d = 16'd0;
            end else if (digito_stb && digit_ok(digito)) begin
               pin_d   = shift_in(pin_q, digito);
               cnt_d   = cnt_inc_s;
               timer_d = 16'd0;
               if (cnt_inc_s == DIGITS_C) begin
                  pin_valido_d = 1'b1;
                  state_d      = ST_ENVIO;
               end else begin
                  state_d = ST_CAPTURA;
               end
            end else if (digito_stb) begin
               // Non-decimal key: flag it, but it still counts as activity.
               error_digito_d = 1'b1;
               timer_d        = 16'd0;
            end else if (timer_q == TIMER_LAST) begin
               timeout_d = 1'b1;
               pin_d     = '0;
               cnt_d     = 4'd0;
               timer_d   = 16'd0;
               state_d   = ST_ESPERA_RETIRO;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end

         ST_ENVIO: begin
            pin_valido_d = 1'b1;
            // Removal outranks a same-cycle acknowledge.
            if (!tarjeta_insertada) begin
               pin_valido_d = 1'b0;
               pin_d        = '0;
               cnt_d        = 4'd0;
               timer_d      = 16'd0;
               state_d      = ST_IDLE;
            end else if (pin_bus.pin_ack) begin
               pin_valido_d = 1'b0;
               pin_d        = '0;
               cnt_d        = 4'd0;
               timer_d      = 16'd0;
               state_d      = ST_ESPERA_RETIRO;
            end else begin
               state_d = ST_ENVIO;
            end
         end

         ST_ESPERA_RETIRO: begin
            pin_valido_d = 1'b0;
            pin_d        = '0;
            cnt_d        = 4'd0;
            timer_d      = 16'd0;
            if (!tarjeta_insertada) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ESPERA_RETIRO;
            end
         end

         default: begin
            pin_valido_d = 1'b0;
            pin_d        = '0;
            cnt_d        = 4'd0;
            timer_d      = 16'd0;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q            <= ST_IDLE;
         card_prev_q        <= 1'b0;
         pin_q              <= '0;
         cnt_q              <= 4'd0;
         timer_q            <= 16'd0;
         tarjeta_recibida_q <= 1'b0;
         pin_valido_q       <= 1'b0;
         timeout_q          <= 1'b0;
         error_digito_q     <= 1'b0;
      end else begin
         state_q            <= state_d;
         card_prev_q        <= card_prev_d;
         pin_q              <= pin_d;
         cnt_q              <= cnt_d;
         timer_q            <= timer_d;
         tarjeta_recibida_q <= tarjeta_recibida_d;
         pin_valido_q       <= pin_valido_d;
         timeout_q          <= timeout_d;
         error_digito_q     <= error_digito_d;
      end
   end

   assign pin_bus.tarjeta_recibida = tarjeta_recibida_q;
   assign pin_bus.pin              = pin_q;
   assign pin_bus.pin_valido       = pin_valido_q;
   assign digitos_cnt              = cnt_q;
   assign timeout                  = timeout_q;
   assign error_digito             = error_digito_q;

endmodule : keypad_pin_tx

// File: tb/tb_keypad_pin_tx.sv
// -----------------------------------------------------------------------------
// tb_keypad_pin_tx
// Directed self-checking bench for keypad_pin_tx (DIGITS=4, TIMEOUT=20).
// Inputs change #1 after a rising edge; outputs are sampled #1 after the edge.
// -----------------------------------------------------------------------------
module tb_keypad_pin_tx;

   localparam int DIGITS  = 4;
   localparam int TIMEOUT = 20;

   logic       clk               = 1'b0;
   logic       reset             = 1'b0;
   logic       tarjeta_insertada = 1'b0;
   logic       digito_stb        = 1'b0;
   logic [3:0] digito            = 4'd0;
   logic       borrar            = 1'b0;
   logic [3:0] digitos_cnt;
   logic       timeout;
   logic       error_digito;

   int n_checks = 0;
   int n_errors = 0;
   int first_k;
   int n_pulses;

   keypad_pin_tx_if #(.DIGITS(DIGITS)) pin_bus ();

   keypad_pin_tx #(
      .DIGITS  (DIGITS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .tarjeta_insertada (tarjeta_insertada),
      .digito_stb        (digito_stb),
      .digito            (digito),
      .borrar            (borrar),
      .pin_bus           (pin_bus),
      .digitos_cnt       (digitos_cnt),
      .timeout           (timeout),
      .error_digito      (error_digito)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic press(input logic [3:0] d);
      digito_stb = 1'b1;
      digito     = d;
      tick();
      digito_stb = 1'b0;
      digito     = 4'd0;
   endtask

   initial begin
      pin_bus.pin_ack = 1'b0;

      // ---- reset state ----
      idle(2);
      check_eq("rst_cnt",   32'(digitos_cnt), 32'd0);
      check_eq("rst_pin",   32'(pin_bus.pin), 32'd0);
      check_eq("rst_valid", 32'(pin_bus.pin_valido), 32'd0);
      check_eq("rst_rec",   32'(pin_bus.tarjeta_recibida), 32'd0);
      check_eq("rst_to",    32'(timeout), 32'd0);
      reset = 1'b1;
      idle(2);
      check_eq("idle_rec",  32'(pin_bus.tarjeta_recibida), 32'd0);

      // ---- session 1: 1,2,3,4 with gaps ----
      tarjeta_insertada = 1'b1;
      tick();
      check_eq("s1_rec_pulse", 32'(pin_bus.tarjeta_recibida), 32'd1);
      tick();
      check_eq("s1_rec_end",   32'(pin_bus.tarjeta_recibida), 32'd0);
      press(4'd1); idle(2);
      press(4'd2); idle(3);
      press(4'd3);
      check_eq("s1_cnt3",   32'(digitos_cnt), 32'd3);
      check_eq("s1_pin3",   32'(pin_bus.pin), 32'h0123);
      check_eq("s1_valid3", 32'(pin_bus.pin_valido), 32'd0);
      idle(2);
      press(4'd4);
      check_eq("s1_valid", 32'(pin_bus.pin_valido), 32'd1);
      check_eq("s1_pin",   32'(pin_bus.pin), 32'h1234);
      check_eq("s1_cnt",   32'(digitos_cnt), 32'd4);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) press(4'd6); else tick();
         check_eq("s1_hold_valid", 32'(pin_bus.pin_valido), 32'd1);
         check_eq("s1_hold_pin",   32'(pin_bus.pin), 32'h1234);
         check_eq("s1_hold_rec",   32'(pin_bus.tarjeta_recibida), 32'd0);
      end
      pin_bus.pin_ack = 1'b1;
      tick();
      pin_bus.pin_ack = 1'b0;
      check_eq("s1_ack_valid", 32'(pin_bus.pin_valido), 32'd0);
      check_eq("s1_ack_pin",   32'(pin_bus.pin), 32'd0);
      idle(3);
      press(4'd1);
      check_eq("s1_locked_cnt", 32'(digitos_cnt), 32'd0);
      check_eq("s1_locked_rec", 32'(pin_bus.tarjeta_recibida), 32'd0);

      // ---- session 2: 7,8, clear, 9,0,1,2; ack in first valid cycle ----
      tarjeta_insertada = 1'b0; tick();
      tarjeta_insertada = 1'b1; tick();
      check_eq("s2_rec", 32'(pin_bus.tarjeta_recibida), 32'd1);
      press(4'd7); press(4'd8);
      check_eq("s2_cnt2", 32'(digitos_cnt), 32'd2);
      borrar = 1'b1; digito_stb = 1'b1; digito = 4'd7;
      tick();
      borrar = 1'b0; digito_stb = 1'b0; digito = 4'd0;
      check_eq("s2_clr_cnt", 32'(digitos_cnt), 32'd0);
      check_eq("s2_clr_pin", 32'(pin_bus.pin), 32'd0);
      press(4'd9); press(4'd0); press(4'd1); press(4'd2);
      check_eq("s2_pin",   32'(pin_bus.pin), 32'h9012);
      check_eq("s2_valid", 32'(pin_bus.pin_valido), 32'd1);
      pin_bus.pin_ack = 1'b1;
      tick();
      pin_bus.pin_ack = 1'b0;
      check_eq("s2_fast_ack", 32'(pin_bus.pin_valido), 32'd0);

      // ---- session 3: 5, A (rejected), 5,5,5; removal beats ack ----
      tarjeta_insertada = 1'b0; tick();
      tarjeta_insertada = 1'b1; tick();
      check_eq("s3_rec", 32'(pin_bus.tarjeta_recibida), 32'd1);
      press(4'd5);
      press(4'hA);
      check_eq("s3_err",     32'(error_digito), 32'd1);
      check_eq("s3_err_cnt", 32'(digitos_cnt), 32'd1);
      check_eq("s3_err_pin", 32'(pin_bus.pin), 32'h0005);
      tick();
      check_eq("s3_err_end", 32'(error_digito), 32'd0);
      press(4'd5); press(4'd5); press(4'd5);
      check_eq("s3_pin",   32'(pin_bus.pin), 32'h5555);
      check_eq("s3_valid", 32'(pin_bus.pin_valido), 32'd1);
      tarjeta_insertada = 1'b0; pin_bus.pin_ack = 1'b1;
      tick();
      pin_bus.pin_ack = 1'b0;
      check_eq("s3_rm_valid", 32'(pin_bus.pin_valido), 32'd0);
      check_eq("s3_rm_pin",   32'(pin_bus.pin), 32'd0);
      // Back in IDLE: re-insertion must pulse immediately.
      tarjeta_insertada = 1'b1; tick();
      check_eq("s3_idle_rec", 32'(pin_bus.tarjeta_recibida), 32'd1);

      // ---- inactivity timeout with no keys ----
      first_k = 0; n_pulses = 0;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (timeout) begin
            n_pulses++;
            if (first_k == 0) first_k = k;
         end
      end
      check_eq("to_cycle", 32'(first_k), 32'(TIMEOUT));
      check_eq("to_count", 32'(n_pulses), 32'd1);
      press(4'd1);
      check_eq("to_locked_cnt", 32'(digitos_cnt), 32'd0);
      press(4'hB);
      check_eq("to_locked_err", 32'(error_digito), 32'd0);

      // ---- key in the expiry cycle wins ----
      tarjeta_insertada = 1'b0; tick();
      tarjeta_insertada = 1'b1; tick();
      check_eq("tk_rec", 32'(pin_bus.tarjeta_recibida), 32'd1);
      idle(TIMEOUT - 1);
      press(4'd2);
      check_eq("tk_no_to", 32'(timeout), 32'd0);
      check_eq("tk_cnt",   32'(digitos_cnt), 32'd1);
      first_k = 0; n_pulses = 0;
      for (int k = 1; k <= 22; k++) begin
         tick();
         if (timeout) begin
            n_pulses++;
            if (first_k == 0) first_k = k;
         end
      end
      check_eq("tk_to_cycle", 32'(first_k), 32'(TIMEOUT));
      check_eq("tk_to_count", 32'(n_pulses), 32'd1);
      check_eq("tk_to_cnt",   32'(digitos_cnt), 32'd0);

      // ---- reset mid-capture, card left in ----
      tarjeta_insertada = 1'b0; tick();
      tarjeta_insertada = 1'b1; tick();
      press(4'd1); press(4'd2);
      check_eq("rs_cnt_pre", 32'(digitos_cnt), 32'd2);
      reset = 1'b0;
      #1;
      check_eq("rs_async_cnt", 32'(digitos_cnt), 32'd0);
      check_eq("rs_async_pin", 32'(pin_bus.pin), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      check_eq("rs_rec",  32'(pin_bus.tarjeta_recibida), 32'd1);
      check_eq("rs_cnt",  32'(digitos_cnt), 32'd0);
      tick();
      check_eq("rs_rec_end", 32'(pin_bus.tarjeta_recibida), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_keypad_pin_tx
